// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
//   XLEN : writeback data width
//   AW   : register address width
//   NREG : number of architectural registers (2**AW)
//   req_id_e : writeback requester identifier, also used as the
//              round-robin pointer encoding (REQ_ALU = preferred after reset)
package regfile_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard.
//   clk, rst       : clock, asynchronous active-low reset
//   set_en/set_idx : mark a register pending (issue fire)
//   clr_en/clr_idx : clear a register at its commit grant
//   iss_*          : issuing instruction operands for hazard detection
//   stall          : RAW/WAW hazard against a pending register
//   busy           : at least one register pending
//   err            : sticky, commit to a non-zero register that was not pending
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned AW   = regfile_pkg::AW,
    parameter int unsigned NREG = regfile_pkg::NREG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rs1,
    input  logic [AW-1:0] iss_rs2,
    input  logic [AW-1:0] iss_rd,
    input  logic          iss_wb,
    output logic          stall,
    output logic          busy,
    output logic          err
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    // Set and clear never target the same register (WAW stall prevents it),
    // so their order here does not matter; x0 is forced back to 0.
    always_comb begin
        pend_nxt = pend;
        if (set_en) pend_nxt[set_idx] = 1'b1;
        if (clr_en) pend_nxt[clr_idx] = 1'b0;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
            err  <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (clr_en && (clr_idx != '0) && !pend[clr_idx])
                err <= 1'b1;
        end
    end

    always_comb begin
        stall = iss_valid && (pend[iss_rs1] || pend[iss_rs2] ||
                              (iss_wb && pend[iss_rd]));
    end

    assign busy = |pend;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between the ALU and load
// writeback requesters and tracks in-flight writes for issue hazards.
//   clk, rst                    : clock, asynchronous active-low reset
//   iss_valid/rs1/rs2/rd/wb     : issuing instruction; iss_stall = hold issue
//   alu_valid/rd/data, alu_ready: ALU writeback handshake
//   mem_valid/rd/data, mem_ready: load writeback handshake
//   regWrite/writeReg/writeData : registered write port to the register file
//   busy                        : at least one register pending
//   err                         : sticky commit-without-pending flag
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = regfile_pkg::XLEN,
    parameter int unsigned AW   = regfile_pkg::AW,
    parameter int unsigned NREG = regfile_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_wb,
    output logic            iss_stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            regWrite,
    output logic [AW-1:0]   writeReg,
    output logic [XLEN-1:0] writeData,
    output logic            busy,
    output logic            err
);

    req_id_e         rr_ptr;
    logic            grant;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;
    logic            fire;

    // MEM wins when it is alone or when both request and the pointer names it.
    always_comb begin
        mem_ready = mem_valid && (!alu_valid || (rr_ptr == REQ_MEM));
        alu_ready = alu_valid && !mem_ready;
        grant     = alu_ready || mem_ready;
        gnt_rd    = mem_ready ? mem_rd   : alu_rd;
        gnt_data  = mem_ready ? mem_data : alu_data;
    end

    assign fire = iss_valid && !iss_stall && iss_wb && (iss_rd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= REQ_ALU;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            regWrite <= grant && (gnt_rd != '0);
            if (grant) begin
                writeReg  <= gnt_rd;
                writeData <= gnt_data;
            end
            if (alu_valid && mem_valid)
                rr_ptr <= (rr_ptr == REQ_ALU) ? REQ_MEM : REQ_ALU;
        end
    end

    rf_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (fire),
        .set_idx   (iss_rd),
        .clr_en    (grant),
        .clr_idx   (gnt_rd),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_wb    (iss_wb),
        .stall     (iss_stall),
        .busy      (busy),
        .err       (err)
    );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: issue/stall, arbitration,
// commit latency, error flag and asynchronous reset.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_wb;
    logic        iss_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler #(
        .XLEN (32),
        .AW   (5),
        .NREG (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_wb    (iss_wb),
        .iss_stall (iss_stall),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wb);
        iss_valid = v;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_rd    = rd;
        iss_wb    = wb;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mem_valid = v;
        mem_rd    = rd;
        mem_data  = d;
    endtask

    initial begin
        rst = 1'b0;
        iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        alu(1'b0, 5'd0, 32'h0);
        mem(1'b0, 5'd0, 32'h0);
        #3;
        chk("rst_regWrite",  {31'd0, regWrite}, 32'd0);
        chk("rst_writeReg",  {27'd0, writeReg}, 32'd0);
        chk("rst_writeData", writeData, 32'd0);
        chk("rst_err",       {31'd0, err}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: issue rd=5, no sources pending
        iss(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        #1 chk("s1_stall", {31'd0, iss_stall}, 32'd0);
        tick();

        // 2: RAW probe on x5, ALU commits x5
        iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("s2_busy",      {31'd0, busy}, 32'd1);
        chk("s2_raw_stall", {31'd0, iss_stall}, 32'd1);
        chk("s2_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("s2_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();

        // 3: commit visible, stall on x5 drops; issue rd=3 in the same cycle
        alu(1'b0, 5'd0, 32'h0);
        iss(1'b1, 5'd5, 5'd0, 5'd3, 1'b1);
        #1;
        chk("s3_regWrite",  {31'd0, regWrite}, 32'd1);
        chk("s3_writeReg",  {27'd0, writeReg}, 32'd5);
        chk("s3_writeData", writeData, 32'hDEADBEEF);
        chk("s3_stall",     {31'd0, iss_stall}, 32'd0);
        chk("s3_busy",      {31'd0, busy}, 32'd0);
        tick();

        // 4: idle write port holds, issue rd=4
        iss(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        #1;
        chk("s4_regWrite",  {31'd0, regWrite}, 32'd0);
        chk("s4_writeReg",  {27'd0, writeReg}, 32'd5);
        chk("s4_writeData", writeData, 32'hDEADBEEF);
        chk("s4_stall",     {31'd0, iss_stall}, 32'd0);
        chk("s4_busy",      {31'd0, busy}, 32'd1);
        tick();

        // 5: both valid, pointer prefers ALU
        iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        alu(1'b1, 5'd3, 32'h33);
        mem(1'b1, 5'd4, 32'h44);
        #1;
        chk("s5_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("s5_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();

        // 6: both valid again (ALU now x0), pointer prefers MEM
        alu(1'b1, 5'd0, 32'h11);
        #1;
        chk("s6_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("s6_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("s6_regWrite",  {31'd0, regWrite}, 32'd1);
        chk("s6_writeReg",  {27'd0, writeReg}, 32'd3);
        chk("s6_writeData", writeData, 32'h33);
        tick();

        // 7: MEM commit visible; ALU alone is granted
        mem(1'b0, 5'd0, 32'h0);
        #1;
        chk("s7_regWrite",  {31'd0, regWrite}, 32'd1);
        chk("s7_writeReg",  {27'd0, writeReg}, 32'd4);
        chk("s7_writeData", writeData, 32'h44);
        chk("s7_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("s7_busy",      {31'd0, busy}, 32'd0);
        tick();

        // 8: x0 commit suppresses regWrite; pointer back at ALU
        alu(1'b1, 5'd0, 32'h22);
        mem(1'b1, 5'd0, 32'h55);
        #1;
        chk("s8_regWrite",  {31'd0, regWrite}, 32'd0);
        chk("s8_writeReg",  {27'd0, writeReg}, 32'd0);
        chk("s8_writeData", writeData, 32'h11);
        chk("s8_err",       {31'd0, err}, 32'd0);
        chk("s8_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("s8_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();

        // 9: MEM alone
        alu(1'b0, 5'd0, 32'h0);
        #1;
        chk("s9_writeData", writeData, 32'h22);
        chk("s9_mem_ready", {31'd0, mem_ready}, 32'd1);
        tick();

        // 10: commit to non-pending x7
        mem(1'b0, 5'd0, 32'h0);
        alu(1'b1, 5'd7, 32'h77);
        #1;
        chk("s10_writeData", writeData, 32'h55);
        chk("s10_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("s10_err",       {31'd0, err}, 32'd0);
        tick();

        // 11: err set; issue rd=9
        alu(1'b0, 5'd0, 32'h0);
        iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        #1;
        chk("s11_err",      {31'd0, err}, 32'd1);
        chk("s11_regWrite", {31'd0, regWrite}, 32'd1);
        chk("s11_writeReg", {27'd0, writeReg}, 32'd7);
        chk("s11_stall",    {31'd0, iss_stall}, 32'd0);
        tick();

        // 12: WAW on x9
        #1;
        chk("s12_waw_stall", {31'd0, iss_stall}, 32'd1);
        chk("s12_err",       {31'd0, err}, 32'd1);
        tick();

        // 13: issue rd=10 while x9 commits
        iss(1'b1, 5'd0, 5'd0, 5'd10, 1'b1);
        alu(1'b1, 5'd9, 32'h99);
        #1;
        chk("s13_stall",     {31'd0, iss_stall}, 32'd0);
        chk("s13_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();

        // 14: x9 cleared, x10 pending; issue rd=11
        alu(1'b0, 5'd0, 32'h0);
        iss(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        #1;
        chk("s14_regWrite", {31'd0, regWrite}, 32'd1);
        chk("s14_writeReg", {27'd0, writeReg}, 32'd9);
        chk("s14_x9_clear", {31'd0, iss_stall}, 32'd0);
        iss(1'b1, 5'd0, 5'd10, 5'd0, 1'b0);
        #1 chk("s14_x10_pend", {31'd0, iss_stall}, 32'd1);
        iss(1'b1, 5'd0, 5'd0, 5'd11, 1'b1);
        #1 chk("s14_stall", {31'd0, iss_stall}, 32'd0);
        tick();

        // 15: issue rd=12 while x7 commits again
        iss(1'b1, 5'd0, 5'd0, 5'd12, 1'b1);
        alu(1'b1, 5'd7, 32'h77);
        #1;
        chk("s15_stall",     {31'd0, iss_stall}, 32'd0);
        chk("s15_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();

        // 16: asynchronous reset with write in flight and x10..x12 pending
        iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        alu(1'b0, 5'd0, 32'h0);
        #1;
        chk("s16_regWrite", {31'd0, regWrite}, 32'd1);
        chk("s16_busy",     {31'd0, busy}, 32'd1);
        chk("s16_err",      {31'd0, err}, 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_regWrite",  {31'd0, regWrite}, 32'd0);
        chk("ar_busy",      {31'd0, busy}, 32'd0);
        chk("ar_err",       {31'd0, err}, 32'd0);
        chk("ar_writeReg",  {27'd0, writeReg}, 32'd0);
        chk("ar_writeData", writeData, 32'd0);
        rst = 1'b1;
        tick();

        iss(1'b1, 5'd10, 5'd11, 5'd12, 1'b1);
        #1;
        chk("post_stall", {31'd0, iss_stall}, 32'd0);
        chk("post_busy",  {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
